// File: rtl/lfsr_gen_if.sv
// Control and status bundle for lfsr_gen: step/load controls in, state and cycle status out.
// Master drives the controls, slave (the generator) drives the state and status.
interface lfsr_gen_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic             mode;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             wrap;
    logic [WIDTH-1:0] period;
    logic             lockup;

    modport master (
        output en, load, seed, mode,
        input  q, sout, wrap, period, lockup
    );

    modport slave (
        input  en, load, seed, mode,
        output q, sout, wrap, period, lockup
    );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with run-time Fibonacci/Galois selection, seed load,
// all-zero lock-up recovery and measurement of the sequence period.
module lfsr_gen #(
    parameter int unsigned      WIDTH      = 4,
    parameter logic [WIDTH-1:0] TAPS       = 4'b1100,
    parameter logic [WIDTH-1:0] POLY       = 4'b1001,
    parameter logic [WIDTH-1:0] RESET_SEED = 4'b0001
) (
    input logic        clk,
    input logic        rst,
    lfsr_gen_if.slave  bus
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;

    logic             fib_fb;
    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic [WIDTH-1:0] step_next;

    always_comb begin
        fib_fb    = ^(q_q & TAPS);
        fib_next  = {q_q[WIDTH-2:0], fib_fb};
        gal_next  = {q_q[WIDTH-2:0], 1'b0} ^ (q_q[WIDTH-1] ? POLY : '0);
        step_next = bus.mode ? gal_next : fib_next;
    end

    always_comb begin
        q_d      = q_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;

        if (bus.load) begin
            q_d     = bus.seed;
            start_d = bus.seed;
            cnt_d   = '0;
        end else if (bus.en) begin
            if (q_q == '0) begin
                // All-zero is a fixed point of both forms; restart instead of counting a step.
                q_d      = RESET_SEED;
                start_d  = RESET_SEED;
                cnt_d    = '0;
                lockup_d = 1'b1;
            end else begin
                q_d = step_next;
                if (step_next == start_q) begin
                    wrap_d   = 1'b1;
                    period_d = cnt_q + WIDTH'(1);
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q      <= RESET_SEED;
            start_q  <= RESET_SEED;
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign bus.q      = q_q;
    assign bus.sout   = q_q[WIDTH-1];
    assign bus.wrap   = wrap_q;
    assign bus.period = period_q;
    assign bus.lockup = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen (WIDTH=4): directed sequences plus randomized traffic,
// all checked against an arithmetic reference model of the generator.
module tb_lfsr_gen;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lfsr_gen_if #(.WIDTH(W)) bus ();

    lfsr_gen #(
        .WIDTH      (W),
        .TAPS       (4'b1100),
        .POLY       (4'b1001),
        .RESET_SEED (4'b0001)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_q, m_start, m_cnt, m_period, m_wrap, m_lock;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Successor from the polynomial rules, using integer shifts and bit parity.
    function automatic int next_val(input int q, input int mode);
        int shifted;
        int parity;
        shifted = (q * 2) % 16;
        if (mode == 0) begin
            parity = 0;
            for (int i = 0; i < 4; i++) begin
                if (((q >> i) & 1) == 1 && ((12 >> i) & 1) == 1) parity = parity ^ 1;
            end
            return shifted + parity;
        end
        return (q >= 8) ? (shifted ^ 9) : shifted;
    endfunction

    task automatic model_edge();
        int n;
        m_wrap = 0;
        m_lock = 0;
        if (rst) begin
            m_q = 1; m_start = 1; m_cnt = 0; m_period = 0;
        end else if (bus.load) begin
            m_q = int'(bus.seed); m_start = m_q; m_cnt = 0;
        end else if (bus.en) begin
            if (m_q == 0) begin
                m_q = 1; m_start = 1; m_cnt = 0; m_lock = 1;
            end else begin
                n = next_val(m_q, int'(bus.mode));
                m_q = n;
                if (n == m_start) begin
                    m_wrap = 1;
                    m_period = m_cnt + 1;
                    m_cnt = 0;
                end else begin
                    m_cnt = (m_cnt + 1) % 16;
                end
            end
        end
    endtask

    // One clock: update the model with the inputs seen at the edge, then compare.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("q", int'(bus.q), m_q);
        check_eq("sout", int'(bus.sout), (m_q >> 3) & 1);
        check_eq("wrap", int'(bus.wrap), m_wrap);
        check_eq("lockup", int'(bus.lockup), m_lock);
        check_eq("period", int'(bus.period), m_period);
    endtask

    int fib_tab [15] = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};
    int gal_tab [6]  = '{2, 4, 8, 9, 11, 15};

    initial begin
        m_q = 0; m_start = 0; m_cnt = 0; m_period = 0; m_wrap = 0; m_lock = 0;
        rst = 1'b1;
        bus.en = 1'b0; bus.load = 1'b0; bus.seed = '0; bus.mode = 1'b0;

        // Reset
        cycle();
        check_eq("rst_q", int'(bus.q), 1);
        check_eq("rst_period", int'(bus.period), 0);
        rst = 1'b0;

        // Fibonacci full cycle
        bus.en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            cycle();
            check_eq("fib_seq", int'(bus.q), fib_tab[i]);
            check_eq("fib_wrap", int'(bus.wrap), (i == 14) ? 1 : 0);
        end
        check_eq("fib_period", int'(bus.period), 15);

        // Galois from seed 0001
        bus.mode = 1'b1; bus.load = 1'b1; bus.seed = 4'b0001;
        cycle();
        bus.load = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (i < 6) check_eq("gal_seq", int'(bus.q), gal_tab[i]);
        end
        check_eq("gal_wrap", int'(bus.wrap), 1);
        check_eq("gal_period", int'(bus.period), 15);

        // Zero seed lock-up recovery
        bus.mode = 1'b0; bus.load = 1'b1; bus.en = 1'b0; bus.seed = 4'b0000;
        cycle();
        bus.load = 1'b0;
        cycle();
        cycle();
        check_eq("zero_hold", int'(bus.q), 0);
        bus.en = 1'b1;
        cycle();
        check_eq("lock_q", int'(bus.q), 1);
        check_eq("lock_pulse", int'(bus.lockup), 1);
        check_eq("lock_period", int'(bus.period), 15);
        bus.en = 1'b0;
        cycle();
        check_eq("lock_once", int'(bus.lockup), 0);

        // Gated stepping: one enabled cycle, two idle
        for (int i = 0; i < 15; i++) begin
            bus.en = 1'b1;
            cycle();
            check_eq("gated_seq", int'(bus.q), fib_tab[i]);
            check_eq("gated_wrap", int'(bus.wrap), (i == 14) ? 1 : 0);
            bus.en = 1'b0;
            cycle();
            cycle();
        end
        check_eq("gated_period", int'(bus.period), 15);

        // Load wins over en
        bus.load = 1'b1; bus.en = 1'b1; bus.seed = 4'b0110;
        cycle();
        check_eq("ld_en_q", int'(bus.q), 6);
        bus.load = 1'b0;
        cycle();
        check_eq("ld_step", int'(bus.q), 13);
        for (int i = 0; i < 14; i++) cycle();
        check_eq("ld_wrap_q", int'(bus.q), 6);
        check_eq("ld_wrap", int'(bus.wrap), 1);

        // Reset mid-run at q=1010
        bus.load = 1'b1; bus.seed = 4'b0001;
        cycle();
        bus.load = 1'b0;
        for (int i = 0; i < 7; i++) cycle();
        check_eq("mid_q", int'(bus.q), 10);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("mid_rst_q", int'(bus.q), 1);
        check_eq("mid_rst_period", int'(bus.period), 0);
        cycle();
        check_eq("mid_restart", int'(bus.q), 2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 99) < 2);
            bus.load = ($urandom_range(0, 99) < 8);
            bus.en   = ($urandom_range(0, 99) < 75);
            bus.seed = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 5) bus.mode = ~bus.mode;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
